// File: rtl/regfile_write_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : regfile_write_sequencer
// | Brief   : Burst write-port driver for a 2**w1 x w2 register file, fed by a
// |           valid/ready data stream, with a one-shot clear-all command.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
module regfile_write_sequencer #(
  parameter int w1 = 2,
  parameter int w2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [w1-1:0]     base,
  input  logic [w1:0]       len,
  input  logic              clear_all,
  input  logic [w2-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [w1-1:0]     s,
  output logic              e,
  output logic [w2-1:0]     d,
  output logic [(1<<w1)-1:0] clr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    c_IDLE  = 2'd0,
    c_LOAD  = 2'd1,
    c_CLEAR = 2'd2,
    c_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [w1-1:0] r_ptr;
  logic [w1:0]   r_remaining;
  logic          w_hs;
  logic          w_burst_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_burst_go  = 1'b0;
    case (r_state)
      c_IDLE: begin
        // clear_all wins; a simultaneous start is dropped, not queued
        if (clear_all) begin
          w_state_nxt = c_CLEAR;
        end else if (start) begin
          if (len != '0) begin
            w_burst_go  = 1'b1;
            w_state_nxt = c_LOAD;
          end else begin
            w_state_nxt = c_DONE;
          end
        end
      end
      c_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && r_remaining == (w1+1)'(1)) w_state_nxt = c_DONE;
      end
      c_CLEAR: w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  assign w_hs = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_burst_go) begin
      r_ptr       <= base;
      r_remaining <= len;
    end else if (w_hs) begin
      r_ptr       <= r_ptr + w1'(1);
      r_remaining <= r_remaining - (w1+1)'(1);
    end
  end

  // Outputs are registered from the next-state decode so done lines up with the last e.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      e    <= 1'b0;
      d    <= '0;
      clr  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      e    <= w_hs;
      clr  <= (w_state_nxt == c_CLEAR) ? '1 : '0;
      busy <= (w_state_nxt != c_IDLE);
      done <= (w_state_nxt == c_DONE);
      if (w_hs) begin
        s <= r_ptr;
        d <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : tb_regfile_write_sequencer
// | Brief   : Directed cycle-table bench for regfile_write_sequencer.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_regfile_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] base;
  logic [2:0] len;
  logic       clear_all;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] s;
  logic       e;
  logic [7:0] d;
  logic [3:0] clr;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_sequencer #(.w1(2), .w2(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .clear_all(clear_all), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .s(s), .e(e), .d(d), .clr(clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One row per cycle: inputs driven that cycle, outputs expected in that same cycle.
  typedef struct {
    logic       start;
    logic [1:0] base;
    logic [2:0] len;
    logic       clear_all;
    logic [7:0] data;
    logic       valid;
    logic       rdy;
    logic       e;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] clr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic [1:0] b, input logic [2:0] l,
                              input logic ca, input logic [7:0] dat, input logic v,
                              input logic x_rdy, input logic x_e, input logic [1:0] x_s,
                              input logic [7:0] x_d, input logic [3:0] x_clr,
                              input logic x_busy, input logic x_done);
    vec_t r;
    r.start = st; r.base = b; r.len = l; r.clear_all = ca; r.data = dat; r.valid = v;
    r.rdy = x_rdy; r.e = x_e; r.s = x_s; r.d = x_d; r.clr = x_clr;
    r.busy = x_busy; r.done = x_done;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " e"}, 32'(e), 32'd0);
    chk({tag, " s"}, 32'(s), 32'd0);
    chk({tag, " d"}, 32'(d), 32'd0);
    chk({tag, " clr"}, 32'(clr), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic idle_inputs();
    start = 0; base = 0; len = 0; clear_all = 0; in_data = 0; in_valid = 0;
  endtask

  initial begin
    //   st b  len ca data   v    rdy e  s  d      clr    busy done
    // full burst base=0 len=4
    add(1, 0, 4, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'h0, 0, 0);
    add(0, 0, 0, 0, 8'h01, 1,   1, 0, 0, 8'h00, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h02, 1,   1, 1, 0, 8'h01, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h04, 1,   1, 1, 1, 8'h02, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h08, 1,   1, 1, 2, 8'h04, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0,   0, 1, 3, 8'h08, 4'h0, 1, 1);
    // wrap-around base=3 len=3
    add(1, 3, 3, 0, 8'h00, 0,   0, 0, 3, 8'h08, 4'h0, 0, 0);
    add(0, 0, 0, 0, 8'hA1, 1,   1, 0, 3, 8'h08, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'hA2, 1,   1, 1, 3, 8'hA1, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'hA3, 1,   1, 1, 0, 8'hA2, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0,   0, 1, 1, 8'hA3, 4'h0, 1, 1);
    // stream gaps base=1 len=2, with a start during LOAD that must be ignored
    add(1, 1, 2, 0, 8'h00, 0,   0, 0, 1, 8'hA3, 4'h0, 0, 0);
    add(0, 0, 0, 0, 8'h55, 1,   1, 0, 1, 8'hA3, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h66, 0,   1, 1, 1, 8'h55, 4'h0, 1, 0);
    add(1, 0, 4, 0, 8'h6A, 0,   1, 0, 1, 8'h55, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h77, 1,   1, 0, 1, 8'h55, 4'h0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0,   0, 1, 2, 8'h77, 4'h0, 1, 1);
    // clear_all beats start; start during CLEAR ignored
    add(1, 0, 4, 1, 8'h00, 0,   0, 0, 2, 8'h77, 4'h0, 0, 0);
    add(1, 0, 4, 0, 8'h99, 1,   0, 0, 2, 8'h77, 4'hF, 1, 0);
    add(0, 0, 0, 0, 8'h99, 1,   0, 0, 2, 8'h77, 4'h0, 1, 1);
    // zero-length burst
    add(1, 2, 0, 0, 8'h00, 0,   0, 0, 2, 8'h77, 4'h0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,   0, 0, 2, 8'h77, 4'h0, 1, 1);
    // valid in IDLE is not accepted
    add(0, 0, 0, 0, 8'h99, 1,   0, 0, 2, 8'h77, 4'h0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,   0, 0, 2, 8'h77, 4'h0, 0, 0);

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start; base = vecs[i].base; len = vecs[i].len;
      clear_all = vecs[i].clear_all; in_data = vecs[i].data; in_valid = vecs[i].valid;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d e", i), 32'(e), 32'(vecs[i].e));
      chk($sformatf("row%0d s", i), 32'(s), 32'(vecs[i].s));
      chk($sformatf("row%0d d", i), 32'(d), 32'(vecs[i].d));
      chk($sformatf("row%0d clr", i), 32'(clr), 32'(vecs[i].clr));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].done));
      if (e === 1'b1 && clr !== 4'h0) chk($sformatf("row%0d e_clr_excl", i), 32'(clr), 32'd0);
    end

    // Abort: async reset mid-cycle after two writes of a len=4 burst
    @(negedge clk);
    idle_inputs(); start = 1; base = 0; len = 4;
    @(negedge clk);
    idle_inputs(); in_valid = 1; in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_data = 8'h33;
    #1;
    chk("abort pre e", 32'(e), 32'd1);
    chk("abort pre s", 32'(s), 32'd1);
    chk("abort pre d", 32'(d), 32'h22);
    chk("abort pre busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    in_data = 8'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_abort%0d e", k), 32'(e), 32'd0);
      chk($sformatf("post_abort%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("post_abort%0d busy", k), 32'(busy), 32'd0);
      chk($sformatf("post_abort%0d d", k), 32'(d), 32'd0);
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded limit, expected finish earlier");
    $fatal(1);
  end

endmodule
`default_nettype wire
